// File: rtl/accessor_job_sched.sv
// Two-requester job scheduler in front of a BRAM accessor: round-robin grant,
// row-count validation, run/drain sequencing and a per-job watchdog.
module accessor_job_sched #(
  parameter int CNT_BIT     = 31,
  parameter int MAX_COUNT   = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_i,
  input  logic               req1_i,
  input  logic [CNT_BIT-1:0] count0_i,
  input  logic [CNT_BIT-1:0] count1_i,
  output logic               ack0_o,
  output logic               ack1_o,
  output logic               done0_o,
  output logic               done1_o,
  output logic               err0_o,
  output logic               err1_o,
  output logic               start_run_o,
  output logic [CNT_BIT-1:0] run_count_o,
  input  logic               acc_idle_i,
  input  logic               acc_done_i,
  output logic               busy_o,
  output logic               owner_o,
  output logic [15:0]        job_cnt_o
);

  localparam int WD_W = ($clog2(TIMEOUT_CYC) + 1 > 16) ? $clog2(TIMEOUT_CYC) + 1 : 16;
  localparam logic [WD_W-1:0]    WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_BIT-1:0] CNT_MAX  = CNT_BIT'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [1:0]                req;
  logic [1:0][CNT_BIT-1:0]   cnt_in;
  logic [1:0]                ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic                      run_q, run_d;
  logic [CNT_BIT-1:0]        rc_q, rc_d;
  logic                      own_q, own_d;
  logic                      rr_q, rr_d;
  logic [15:0]               jc_q, jc_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic [1:0]                elig;
  logic                      gnt_idx;
  logic [CNT_BIT-1:0]        gnt_cnt;
  logic                      cnt_ok;

  assign req    = {req1_i, req0_i};
  assign cnt_in = {count1_i, count0_i};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ack_q <= '0;
      done_q <= '0;
      err_q <= '0;
      run_q <= 1'b0;
      rc_q <= '0;
      own_q <= 1'b0;
      rr_q <= 1'b0;
      jc_q <= '0;
      wd_q <= '0;
    end else begin
      state <= state_nxt;
      ack_q <= ack_d;
      done_q <= done_d;
      err_q <= err_d;
      run_q <= run_d;
      rc_q <= rc_d;
      own_q <= own_d;
      rr_q <= rr_d;
      jc_q <= jc_d;
      wd_q <= wd_d;
    end
  end

  // A requester whose ack is on the wire this cycle is still holding its
  // request; mask it so it cannot be granted twice for one job.
  always_comb begin
    elig    = req & ~ack_q;
    gnt_idx = (elig == 2'b11) ? rr_q : elig[1];
    gnt_cnt = cnt_in[gnt_idx];
    cnt_ok  = (gnt_cnt != '0) && (gnt_cnt <= CNT_MAX);
  end

  always_comb begin
    state_nxt = state;
    ack_d     = '0;
    done_d    = '0;
    err_d     = '0;
    run_d     = run_q;
    rc_d      = rc_q;
    own_d     = own_q;
    rr_d      = rr_q;
    jc_d      = jc_q;
    wd_d      = wd_q;
    unique case (state)
      IDLE: begin
        if (acc_idle_i && (elig != 2'b00)) begin
          ack_d[gnt_idx] = 1'b1;
          own_d          = gnt_idx;
          rr_d           = ~gnt_idx;
          if (cnt_ok) begin
            run_d     = 1'b1;
            rc_d      = gnt_cnt;
            wd_d      = '0;
            state_nxt = RUN;
          end else begin
            err_d[gnt_idx] = 1'b1;
          end
        end
      end
      RUN: begin
        // Completion takes priority over a simultaneous watchdog expiry.
        if (acc_done_i) begin
          run_d         = 1'b0;
          done_d[own_q] = 1'b1;
          jc_d          = jc_q + 16'd1;
          state_nxt     = DRAIN;
        end else if (wd_q == WD_LIMIT) begin
          run_d         = 1'b0;
          done_d[own_q] = 1'b1;
          err_d[own_q]  = 1'b1;
          state_nxt     = DRAIN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DRAIN: begin
        if (acc_idle_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ack0_o      = ack_q[0];
  assign ack1_o      = ack_q[1];
  assign done0_o     = done_q[0];
  assign done1_o     = done_q[1];
  assign err0_o      = err_q[0];
  assign err1_o      = err_q[1];
  assign start_run_o = run_q;
  assign run_count_o = rc_q;
  assign owner_o     = own_q;
  assign job_cnt_o   = jc_q;
  assign busy_o      = (state != IDLE);

endmodule
